feature_sequencer: RTL
======================

# feature_sequencer

Upstream stage of the perceptron classifier. Accepts 8-bit feature words over a valid/ready handshake, buffers them in a small FIFO, and presents each word on `current` held stable for exactly one 8-cycle bit-serial evaluation window. It emits frame markers so the classifier and any result capture can align to word boundaries. Back-to-back words stream with no idle cycles between frames.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, 2..16.
- `FRAME_LEN`, 8: cycles each word is held; fixed to the 8 feature bits.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `in_data`  in  8: feature word from the producer.
- `in_valid`  in  1: `in_data` is valid.
- `in_ready`  out  1: FIFO can accept a word this cycle.
- `current`  out  8: word under evaluation; connects to the classifier feature input.
- `bit_index`  out  3: frame phase, 0..7; the bit the classifier consumes this cycle.
- `frame_start`  out  1: one-cycle pulse in phase 0 of every frame.
- `frame_done`  out  1: one-cycle pulse in phase 7 of every frame.
- `frame_active`  out  1: high during every cycle of a frame.
- `occupancy`  out  $clog2(DEPTH)+1: number of words in the FIFO, excluding the word held on `current`.

## Operation
- Push occurs when `in_valid && in_ready`. `in_ready = !full && !rst`. There is no pass-through when full: a pop in the same cycle does not raise `in_ready`.
- The FIFO is circular. Read and write pointers wrap modulo `DEPTH`. `occupancy` is the count register: +1 on push, -1 on pop, unchanged on simultaneous push and pop.
- The FSM has two states, IDLE and RUN.
  - IDLE: if `occupancy != 0` at the edge, pop the head into the `current` register, set phase=0, and go to RUN. Otherwise stay in IDLE.
  - RUN: phase increments each cycle.
    - At the edge ending phase 7, if `occupancy != 0`, pop the next word, set phase=0, and stay in RUN. This gives a back-to-back frame.
    - At the edge ending phase 7, if the FIFO is empty, go to IDLE.
- `current` changes only on a pop. In IDLE it holds the last evaluated word.
- The FIFO is never popped while empty. A push to an empty FIFO is not visible to the FSM until the following edge; there is no bypass.
- Output decode, all derived from registered state:
  - `frame_active` = RUN.
  - `bit_index` = phase. It is 0 in IDLE.
  - `frame_start` = RUN && phase==0.
  - `frame_done` = RUN && phase==7.
- Reset, in any state including mid-frame:
  - Pointers, count and phase clear.
  - FSM goes to IDLE.
  - `current` = 0x00.
  - The aborted frame produces no `frame_done`.
  - FIFO contents are discarded.
- Values of all outputs while `rst` is high and in the first cycle after it deasserts:
  - `current`=0x00, `bit_index`=0, `frame_start`=0, `frame_done`=0, `frame_active`=0, `occupancy`=0.
  - `in_ready`=0 while `rst` is high, and 1 in the first cycle after deassertion.

## Timing
- Latency into an empty, idle block: push accepted at edge E, pop at edge E+1. `frame_start` and the new `current` are visible in the cycle after E+1, 2 cycles after the handshake cycle.
- Each frame is exactly 8 cycles with phases 0..7. `current` is constant for all 8 cycles.
- Sustained throughput is one word per 8 cycles. With a continuous backlog, `frame_done` is immediately followed by `frame_start` on the next cycle.
- `in_ready` can fall in the cycle after the push that fills the FIFO. It rises in the cycle after the pop that frees an entry.
- The producer may hold `in_valid` with changing data while `in_ready`=0. Only handshaken words are stored.

## Test plan
- Reset, then push 0xA5 once.
  - 2 cycles later `current`=0xA5 with `frame_start`=1 and `bit_index`=0.
  - `frame_done`=1 at `bit_index`=7.
  - The block then returns to IDLE with `frame_active`=0 and `current` holding 0xA5.
- Push 0x01, 0x02, 0x03 on consecutive cycles.
  - Three contiguous frames, 24 active cycles with no gap.
  - `frame_start` at cycles 0, 8 and 16 of the burst.
  - `occupancy` peaks at 2, then drains to 0.
- Hold `in_valid`=1 with an incrementing value for 60 cycles (DEPTH=4).
  - `in_ready` drops when `occupancy`=4.
  - Only the words actually accepted appear on `current`, in order, with no loss or duplication.
  - Pointer wrap is exercised more than twice.
- Push and pop in the same cycle while `occupancy`=2: `occupancy` stays at 2.
- Assert `rst` at `bit_index`=4 of a frame with 2 words queued.
  - Next cycle: all outputs at their reset values, no `frame_done`.
  - After release, pushing 0x3C yields a clean frame of 0x3C only.
- With `in_valid`=1 and `occupancy`=4, pop in phase 7: `in_ready` stays 0 that cycle and rises the next cycle.

Source files
------------

// File: rtl/feature_sequencer.sv
// Feature-word sequencer: buffers 8-bit words in a circular FIFO and holds each
// word on `current` for one 8-cycle bit-serial evaluation frame.
module feature_sequencer #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned FRAME_LEN = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [7:0]               current,
    output logic [2:0]               bit_index,
    output logic                     frame_start,
    output logic                     frame_done,
    output logic                     frame_active,
    output logic [$clog2(DEPTH):0]   occupancy
);
    localparam int unsigned AW         = $clog2(DEPTH);
    localparam logic [2:0]  LAST_PHASE = 3'(FRAME_LEN - 1);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    state_t        r_state;
    logic [2:0]    r_phase;
    logic [7:0]    r_current;

    logic          w_full;
    logic          w_push;
    logic          w_pop;

    always_comb begin
        w_full   = (r_count == (AW+1)'(DEPTH));
        // No pass-through: a same-cycle pop never opens a slot for a push.
        in_ready = !w_full && !rst;
        w_push   = in_valid && in_ready;
        w_pop    = (r_count != '0) &&
                   ((r_state == S_IDLE) || (r_phase == LAST_PHASE));
    end

    // Storage needs no reset; clearing the pointers discards the contents.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_state   <= S_IDLE;
            r_phase   <= '0;
            r_current <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr  <= r_rd_ptr + 1'b1;
                r_current <= r_mem[r_rd_ptr];
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            case (r_state)
                S_IDLE: begin
                    r_phase <= '0;
                    if (w_pop) begin
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (r_phase == LAST_PHASE) begin
                        r_phase <= '0;
                        if (!w_pop) begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_phase <= r_phase + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_phase <= '0;
                end
            endcase
        end
    end

    always_comb begin
        current      = r_current;
        bit_index    = r_phase;
        frame_active = (r_state == S_RUN);
        frame_start  = (r_state == S_RUN) && (r_phase == '0);
        frame_done   = (r_state == S_RUN) && (r_phase == LAST_PHASE);
        occupancy    = r_count;
    end
endmodule
